// File: rtl/regfile_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dumper
//  Purpose  : Stalls the core and streams every register-file entry out over
//             a valid/ready port, accumulating an XOR checksum of the beats.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_dumper #(
   parameter int DATA_WIDTH  = 32,
   parameter int REG_NUM     = 32,
   parameter int REG_NUM_BIT = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   hold,
   output logic [REG_NUM_BIT-1:0] rf_raddr,
   input  logic [DATA_WIDTH-1:0]  rf_rdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [REG_NUM_BIT-1:0] out_idx,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   busy,
   output logic                   done,
   output logic [DATA_WIDTH-1:0]  checksum
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [REG_NUM_BIT-1:0] c_last_idx = REG_NUM_BIT'(REG_NUM - 1);
   localparam logic [REG_NUM_BIT-1:0] c_idx_one  = REG_NUM_BIT'(1);

   logic [1:0]             r_state;
   logic [1:0]             w_next_state;
   logic [REG_NUM_BIT-1:0] r_idx;
   logic [REG_NUM_BIT-1:0] r_out_idx;
   logic [DATA_WIDTH-1:0]  r_out_data;
   logic [DATA_WIDTH-1:0]  r_checksum;
   logic [DATA_WIDTH-1:0]  w_captured;
   logic                   w_handshake;
   logic                   w_last;

   // Register 0 is architecturally hard-wired to zero, whatever the RF returns.
   assign w_captured  = (r_idx == '0) ? '0 : rf_rdata;
   assign w_handshake = (r_state == S_SEND) && out_ready;
   assign w_last      = (r_idx == c_last_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_READ;
         S_READ:  w_next_state = S_SEND;
         S_SEND:  if (w_handshake) w_next_state = w_last ? S_DONE : S_READ;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      hold      = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      rf_raddr  = '0;
      case (r_state)
         S_READ: begin
            hold     = 1'b1;
            busy     = 1'b1;
            rf_raddr = r_idx;
         end
         S_SEND: begin
            hold      = 1'b1;
            busy      = 1'b1;
            out_valid = 1'b1;
            rf_raddr  = r_idx;
         end
         S_DONE: begin
            hold     = 1'b1;
            busy     = 1'b1;
            done     = 1'b1;
            rf_raddr = r_idx;
         end
         default: ;
      endcase
   end

   // Beat registers only move in READ, so they are naturally stable across SEND stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_out_idx  <= '0;
         r_out_data <= '0;
         r_checksum <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx      <= '0;
                  r_checksum <= '0;
               end
            end
            S_READ: begin
               r_out_data <= w_captured;
               r_out_idx  <= r_idx;
               r_checksum <= r_checksum ^ w_captured;
            end
            S_SEND: begin
               if (w_handshake && !w_last) begin
                  r_idx <= r_idx + c_idx_one;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_idx  = r_out_idx;
   assign out_data = r_out_data;
   assign checksum = r_checksum;

endmodule
`default_nettype wire
